// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and slow-memory interlock with a watchdog that aborts hung memory accesses
module hazard_stall_unit #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_rs1_en,
  input  logic        id_rs2_en,
  input  logic [3:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        id_is_store,
  input  logic        mem_ready,
  output logic        stall_if_id,
  output logic        bubble_ex,
  output logic        stall_ex_mem,
  output logic        mem_err,
  output logic [15:0] pend_mask
);
  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic ex_v, ex_ld, mem_v, mem_ld;
  logic [3:0] ex_rd, mem_rd;
  logic mem_stall, hazard;
  always_comb begin
    mem_stall = mem_v & ~mem_ready & (state != ERR);
    hazard = id_valid & ex_ld & (state != ERR) &
             ((id_rs1_en & (id_rs1 == ex_rd)) | (id_rs2_en & (id_rs2 == ex_rd)));
    stall_ex_mem = mem_stall;
    bubble_ex = hazard & ~mem_stall;
    stall_if_id = mem_stall | hazard;
    mem_err = state == ERR;
    pend_mask = (16'(ex_ld) << ex_rd) | (16'(mem_ld) << mem_rd);
    state_nx = state;
    wait_cnt_nx = 8'd0;
    // wait_cnt counts stalled cycles so far; the first one is spent in RUN
    case (state)
      RUN: if (mem_v & ~mem_ready) begin
        state_nx = MEMWAIT;
        wait_cnt_nx = 8'd1;
      end
      MEMWAIT: if (mem_ready) state_nx = RUN;
        else if (wait_cnt == 8'(TIMEOUT - 1)) state_nx = ERR;
        else wait_cnt_nx = wait_cnt + 8'd1;
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= 8'd0;
      ex_v <= 1'b0;
      ex_ld <= 1'b0;
      ex_rd <= 4'd0;
      mem_v <= 1'b0;
      mem_ld <= 1'b0;
      mem_rd <= 4'd0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (!mem_stall) begin
        mem_v <= ex_v;
        mem_ld <= ex_ld;
        mem_rd <= ex_rd;
        ex_v <= ~bubble_ex & id_valid & (id_is_load | id_is_store);
        ex_ld <= ~bubble_ex & id_valid & id_is_load & id_rd_we;
        ex_rd <= id_rd;
      end
    end
  end
endmodule
